// File: rtl/vga_pkg.sv
// Shared VGA pixel-pipeline definitions: active-area sizes, 12-bit colour type
// and the eight-colour bar palette.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  localparam rgb12_t PALETTE [8] = '{
    12'hF00, 12'h0F0, 12'h00F, 12'hFF0,
    12'h0FF, 12'hF0F, 12'hFFF, 12'h888
  };

endpackage

// File: rtl/vga_palette_rom.sv
// Combinational 3-bit index to 12-bit colour lookup into the shared palette.
module vga_palette_rom
  import vga_pkg::*;
(
  input  logic [2:0] idx,
  output rgb12_t     rgb
);

  assign rgb = PALETTE[idx];

endmodule

// File: rtl/vga_scroll_bars.sv
// Scrolling colour-bar pixel stage: 2-cycle RGB pipeline with aligned syncs and a
// per-frame scroll offset. Optional macro VGA_SCROLL_BARS_CHECKER_EN inverts bar order on alternate 64-line bands.
module vga_scroll_bars
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int SPEED    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid,
  input  logic [9:0] h_cnt,
  input  logic [9:0] v_cnt,
  input  logic       hsync,
  input  logic       vsync,
  input  logic       en,
  input  logic       dir,
  output logic [3:0] vgaRed,
  output logic [3:0] vgaGreen,
  output logic [3:0] vgaBlue,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic       frame_tick
);

  localparam logic [10:0] H_A11 = 11'(H_ACTIVE);
  localparam logic [10:0] SP11  = 11'(SPEED);

  logic [9:0]  offset;
  logic        vsync_q;
  logic        tick_edge;
  logic [10:0] fwd_sum;
  logic [10:0] fwd_next;
  logic [10:0] rev_next;
  logic [10:0] x_sum;
  logic [10:0] x_wrap;

  logic        s1_valid;
  logic [8:0]  s1_x;
  logic        s1_hsync;
  logic        s1_vsync;
  logic [2:0]  bar_idx;
  rgb12_t      bar_rgb;
  rgb12_t      s2_rgb;
  logic        unused_bits;

  // vsync_q idles at 1 so leaving reset with vsync high never looks like a falling edge.
  assign tick_edge = vsync_q & ~vsync;

  always_comb begin
    fwd_sum  = {1'b0, offset} + SP11;
    fwd_next = (fwd_sum >= H_A11) ? (fwd_sum - H_A11) : fwd_sum;
    rev_next = ({1'b0, offset} < SP11) ? ({1'b0, offset} + (H_A11 - SP11))
                                       : ({1'b0, offset} - SP11);
    x_sum    = {1'b0, h_cnt} + {1'b0, offset};
    x_wrap   = (x_sum >= H_A11) ? (x_sum - H_A11) : x_sum;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vsync_q    <= 1'b1;
      frame_tick <= 1'b0;
      offset     <= '0;
    end else begin
      vsync_q    <= vsync;
      frame_tick <= tick_edge;
      if (tick_edge && en) begin
        offset <= dir ? rev_next[9:0] : fwd_next[9:0];
      end
    end
  end

  // Stage 1: scrolled x plus the side-band signals that must stay aligned with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_x     <= '0;
      s1_hsync <= 1'b1;
      s1_vsync <= 1'b1;
    end else begin
      s1_valid <= valid;
      s1_x     <= x_wrap[8:0];
      s1_hsync <= hsync;
      s1_vsync <= vsync;
    end
  end

`ifdef VGA_SCROLL_BARS_CHECKER_EN
  logic s1_v6;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_v6 <= 1'b0;
    end else begin
      s1_v6 <= v_cnt[6];
    end
  end

  assign bar_idx     = s1_x[8:6] ^ {3{s1_v6}};
  assign unused_bits = ^{x_wrap[10:9], v_cnt[9:7], v_cnt[5:0]};
`else
  assign bar_idx     = s1_x[8:6];
  assign unused_bits = ^{x_wrap[10:9], v_cnt};
`endif

  vga_palette_rom u_palette (
    .idx (bar_idx),
    .rgb (bar_rgb)
  );

  // Stage 2: blank outside active video; syncs take the stage-1 copies.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_rgb    <= '0;
      hsync_out <= 1'b1;
      vsync_out <= 1'b1;
    end else begin
      s2_rgb    <= s1_valid ? bar_rgb : rgb12_t'(12'h000);
      hsync_out <= s1_hsync;
      vsync_out <= s1_vsync;
    end
  end

  assign vgaRed   = s2_rgb.r;
  assign vgaGreen = s2_rgb.g;
  assign vgaBlue  = s2_rgb.b;

endmodule

// File: tb/tb_vga_scroll_bars.sv
// Self-checking bench for vga_scroll_bars: scoreboard of expected pixels/syncs
// plus a per-cycle frame_tick check against a small offset model.
module tb_vga_scroll_bars;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       valid = 1'b0;
  logic [9:0] h_cnt = '0;
  logic [9:0] v_cnt = '0;
  logic       hsync = 1'b1;
  logic       vsync = 1'b1;
  logic       en = 1'b0;
  logic       dir = 1'b0;
  logic [3:0] vgaRed, vgaGreen, vgaBlue;
  logic       hsync_out, vsync_out, frame_tick;

  int checks = 0;
  int errors = 0;

  logic [13:0] exp_q[$];
  logic        exp_tick;
  logic [9:0]  m_off;
  logic        m_vsq;
  logic [11:0] pal [8] = '{12'hF00, 12'h0F0, 12'h00F, 12'hFF0,
                           12'h0FF, 12'hF0F, 12'hFFF, 12'h888};

  vga_scroll_bars #(.H_ACTIVE(640), .SPEED(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .valid      (valid),
    .h_cnt      (h_cnt),
    .v_cnt      (v_cnt),
    .hsync      (hsync),
    .vsync      (vsync),
    .en         (en),
    .dir        (dir),
    .vgaRed     (vgaRed),
    .vgaGreen   (vgaGreen),
    .vgaBlue    (vgaBlue),
    .hsync_out  (hsync_out),
    .vsync_out  (vsync_out),
    .frame_tick (frame_tick)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] exp_rgb(input logic v, input logic [9:0] h,
                                          input logic [9:0] vc, input logic [9:0] off);
    int x;
    logic [2:0] idx;
    if (!v) return 12'h000;
    x   = (int'(h) + int'(off)) % 640;
    idx = 3'((x / 64) % 8);
`ifdef VGA_SCROLL_BARS_CHECKER_EN
    if (vc[6]) idx = ~idx;
`else
    if (vc[6]) idx = idx;
`endif
    return pal[idx];
  endfunction

  // Pipeline holds its reset contents (blank, syncs idle) as the first output after release.
  task automatic model_reset();
    exp_q.delete();
    exp_q.push_back({12'h000, 1'b1, 1'b1});
    exp_tick = 1'b0;
    m_off    = '0;
    m_vsq    = 1'b1;
  endtask

  // Driver: compare previous results at the negedge, then drive the next pixel.
  task automatic step(input logic v, input logic [9:0] h, input logic [9:0] vc,
                      input logic hs, input logic vs, input logic e, input logic d);
    logic [13:0] got;
    logic [13:0] want;
    @(negedge clk);
    check("frame_tick", frame_tick, exp_tick);
    if (exp_q.size() >= 2) begin
      want = exp_q.pop_front();
      got  = {vgaRed, vgaGreen, vgaBlue, hsync_out, vsync_out};
      check("pixel", got, want);
    end
    valid = v; h_cnt = h; v_cnt = vc; hsync = hs; vsync = vs; en = e; dir = d;
    exp_q.push_back({exp_rgb(v, h, vc, m_off), hs, vs});
    exp_tick = m_vsq && !vs;
    if (exp_tick && e) begin
      m_off = d ? 10'((int'(m_off) + 640 - 4) % 640) : 10'((int'(m_off) + 4) % 640);
    end
    m_vsq = vs;
  endtask

  task automatic frame_edge(input logic e, input logic d);
    step(1'b0, 10'd700, 10'd490, 1'b1, 1'b0, e, d);
    step(1'b0, 10'd700, 10'd491, 1'b1, 1'b1, e, d);
  endtask

  initial begin
    model_reset();
    #12;
    check("rst_rgb", {vgaRed, vgaGreen, vgaBlue}, 12'h000);
    check("rst_syncs", {hsync_out, vsync_out}, 2'b11);
    check("rst_tick", frame_tick, 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    model_reset();

    // Static bars, offset 0
    step(1'b1, 10'd0,   10'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 10'd64,  10'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 10'd575, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 10'd639, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 10'd128, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a line
    step(1'b1, 10'd200, 10'd5, 1'b0, 1'b1, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    check("midrst_rgb", {vgaRed, vgaGreen, vgaBlue}, 12'h000);
    check("midrst_syncs", {hsync_out, vsync_out}, 2'b11);
    check("midrst_tick", frame_tick, 1'b0);
    valid = 1'b0; hsync = 1'b1; vsync = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    model_reset();
    step(1'b1, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0);

    // Forward scroll: one edge, then 159 more wrap the offset back to 0
    step(1'b0, 10'd700, 10'd490, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 10'd700, 10'd490, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 10'd700, 10'd491, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 10'd60,  10'd0,   1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 10'd59,  10'd0,   1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 10'd636, 10'd0,   1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 159; i++) frame_edge(1'b1, 1'b0);
    step(1'b1, 10'd0,  10'd0,  1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 10'd63, 10'd0,  1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 10'd64, 10'd0,  1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 10'd0,  10'd64, 1'b1, 1'b1, 1'b1, 1'b0);

    // Reverse wrap from offset 0
    frame_edge(1'b1, 1'b1);
    step(1'b1, 10'd4, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 10'd3, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1);

    // Gating: disabled scroll, blanked pixel, hsync pulse passthrough
    frame_edge(1'b0, 1'b0);
    step(1'b1, 10'd4,  10'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 10'd64, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 10'd656, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 10'd657, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 10'd752, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic v;
      v = 1'($urandom_range(0, 1));
      step(v,
           v ? 10'($urandom_range(0, 639)) : 10'($urandom_range(0, 1023)),
           10'($urandom_range(0, 479)),
           $urandom_range(0, 7) != 0,
           $urandom_range(0, 5) != 0,
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)));
    end

    // Drain
    repeat (3) step(1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
